// File: rtl/router_pkg.sv
// router_pkg
// Shared constants for the 1x3 router: port count, the "no port selected"
// address code and the default soft-reset timeout used by router_sync,
// router_fsm and the output FIFOs.
package router_pkg;

  localparam int NUM_PORTS = 3;

  // Destination address codes carried in the header byte.
  typedef enum logic [1:0] {
    ADDR_P0   = 2'b00,
    ADDR_P1   = 2'b01,
    ADDR_P2   = 2'b10,
    ADDR_NONE = 2'b11
  } addr_e;

  // Default unread-valid timeout and matching counter width (2^CNT_W > TIMEOUT).
  localparam int TIMEOUT_DEF = 30;
  localparam int CNT_W_DEF   = 5;

endpackage

// File: rtl/router_sync_timer.sv
// router_sync_timer
// Per-port supervision timer. Counts consecutive clock edges on which the
// FIFO holds data (vld=1) and nobody reads it (rd=0). On the TIMEOUT-th such
// edge it issues a registered one-cycle soft_reset and restarts the count.
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   vld        in   FIFO holds data
//   rd         in   read strobe for this FIFO
//   soft_reset out  one-cycle registered FIFO soft reset
//   cnt        out  current count (debug visibility)
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             vld,
  input  logic             rd,
  output logic             soft_reset,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;

  // The terminal cycle wraps the count to 0, so after a firing the next
  // pulse needs another full TIMEOUT edges; pulses can never be adjacent.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_soft_reset <= 1'b0;
    end
  end

  assign soft_reset = r_soft_reset;
  assign cnt        = r_cnt;

endmodule

// File: rtl/router_sync.sv
// router_sync
// Address capture and per-port supervision between the router FSM and the
// three output FIFOs. Latches the destination address on detect_add, steers
// the FSM write enable to the addressed FIFO, returns that FIFO's full flag,
// drives per-port valid-out and a timeout soft reset per FIFO.
// Ports:
//   clock, resetn                 clock / async active-low reset
//   detect_add, data_in[1:0]      header decode strobe and address field
//   write_enb_reg                 FSM write request for the current byte
//   read_enb_0/1/2                output-side read strobes
//   empty_0/1/2, full_0/1/2       FIFO status flags
//   write_enb[2:0]                one-hot FIFO write enable
//   fifo_full                     full flag of the addressed FIFO
//   vld_out_0/1/2                 FIFO i holds data
//   soft_reset_0/1/2              one-cycle FIFO soft reset
// Write steering uses the address register as it stands this cycle: when
// detect_add and write_enb_reg coincide, the byte goes to the old address and
// the newly captured address applies from the next cycle. Address 2'b11
// selects nothing: no write enable and fifo_full reads 0.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [1:0]           r_addr;
  logic [NUM_PORTS-1:0] w_vld;
  logic [NUM_PORTS-1:0] w_rd;
  logic [NUM_PORTS-1:0] w_soft_reset;
  logic [CNT_W-1:0]     w_cnt [NUM_PORTS];

  // Address register: captures any data_in value, including the invalid 11.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr <= ADDR_NONE;
    end else if (detect_add) begin
      r_addr <= data_in;
    end
  end

  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (r_addr)
        ADDR_P0: write_enb = 3'b001;
        ADDR_P1: write_enb = 3'b010;
        ADDR_P2: write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
  end

  always_comb begin
    fifo_full = 1'b0;
    case (r_addr)
      ADDR_P0: fifo_full = full_0;
      ADDR_P1: fifo_full = full_1;
      ADDR_P2: fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign w_vld = {~empty_2, ~empty_1, ~empty_0};
  assign w_rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = w_vld[0];
  assign vld_out_1 = w_vld[1];
  assign vld_out_2 = w_vld[2];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (w_vld[p]),
      .rd         (w_rd[p]),
      .soft_reset (w_soft_reset[p]),
      .cnt        (w_cnt[p])
    );
  end

  assign soft_reset_0 = w_soft_reset[0];
  assign soft_reset_1 = w_soft_reset[1];
  assign soft_reset_2 = w_soft_reset[2];

endmodule

// File: tb/tb_router_sync.sv
module tb_router_sync;

  localparam int TO = 30;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic       detect_add = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       write_enb_reg = 1'b0;
  logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
  logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
  logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $error("FAIL %s: observed %0h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One step: advance past the next rising edge; outputs then reflect it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [1:0] a);
    detect_add = 1'b1;
    data_in    = a;
    step();
    detect_add = 1'b0;
  endtask

  // Watchdog: the directed sequence is bounded, this only guards a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    #2;
    push(8'h0); check("rst_write_enb", {5'd0, write_enb});
    push(8'h0); check("rst_fifo_full", {7'd0, fifo_full});
    push(8'h0); check("rst_soft_reset", {5'd0, soft_reset_2, soft_reset_1, soft_reset_0});
    push(8'h0); check("rst_vld_out", {5'd0, vld_out_2, vld_out_1, vld_out_0});
    step();
    resetn = 1'b1;

    // ---- capture 01 with a simultaneous write: old addr (11) steers ----
    detect_add = 1'b1; data_in = 2'b01; write_enb_reg = 1'b1;
    #1;
    push(8'h0); check("cap_cycle_old_addr", {5'd0, write_enb});
    step();
    detect_add = 1'b0;
    #1;
    push(8'h2); check("addr01_write_enb", {5'd0, write_enb});
    full_1 = 1'b1; #1;
    push(8'h1); check("addr01_full1", {7'd0, fifo_full});
    full_1 = 1'b0; full_0 = 1'b1; #1;
    push(8'h0); check("addr01_full0_only", {7'd0, fifo_full});
    full_0 = 1'b0; write_enb_reg = 1'b0; #1;
    push(8'h0); check("addr01_no_wr", {5'd0, write_enb});

    // ---- ports 0 and 2 ----
    write_enb_reg = 1'b1;
    capture(2'b00); #1;
    push(8'h1); check("addr00_write_enb", {5'd0, write_enb});
    full_0 = 1'b1; #1;
    push(8'h1); check("addr00_full0", {7'd0, fifo_full});
    full_0 = 1'b0;
    capture(2'b10); #1;
    push(8'h4); check("addr10_write_enb", {5'd0, write_enb});
    full_2 = 1'b1; #1;
    push(8'h1); check("addr10_full2", {7'd0, fifo_full});

    // ---- invalid address 11 ----
    capture(2'b11);
    full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1; #1;
    push(8'h0); check("addr11_write_enb", {5'd0, write_enb});
    push(8'h0); check("addr11_fifo_full", {7'd0, fifo_full});
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0; write_enb_reg = 1'b0;

    // ---- vld_out follows ~empty (no edge passes while set) ----
    empty_1 = 1'b0; #1;
    push(8'h2); check("vld_out_1", {5'd0, vld_out_2, vld_out_1, vld_out_0});
    empty_1 = 1'b1; #1;

    // ---- port 2 held valid and unread: fires at edges 30 and 60 ----
    empty_2 = 1'b0;
    for (int n = 1; n <= 65; n++) begin
      step();
      push(((n == TO) || (n == 2 * TO)) ? 8'h4 : 8'h0);
      check($sformatf("p2_hold_edge%0d", n), {5'd0, soft_reset_2, soft_reset_1, soft_reset_0});
    end
    empty_2 = 1'b1;
    step();

    // ---- port 0 with a read at edge 20: fires 30 edges after the read ----
    empty_0 = 1'b0;
    for (int n = 1; n <= 52; n++) begin
      read_enb_0 = (n == 20);
      step();
      push((n == 20 + TO) ? 8'h1 : 8'h0);
      check($sformatf("p0_read_edge%0d", n), {5'd0, soft_reset_2, soft_reset_1, soft_reset_0});
    end
    read_enb_0 = 1'b0;
    empty_0 = 1'b1;
    step();

    // ---- all three ports from the same edge ----
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
    for (int n = 1; n <= TO + 1; n++) begin
      step();
      push((n == TO) ? 8'h7 : 8'h0);
      check($sformatf("all_edge%0d", n), {5'd0, soft_reset_2, soft_reset_1, soft_reset_0});
    end
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    step();

    // ---- reset mid-count on port 1 ----
    capture(2'b01);
    write_enb_reg = 1'b1; #1;
    push(8'h2); check("pre_rst_write_enb", {5'd0, write_enb});
    empty_1 = 1'b0;
    for (int n = 1; n <= 25; n++) step();
    push(8'h0); check("p1_before_rst", {5'd0, soft_reset_2, soft_reset_1, soft_reset_0});
    resetn = 1'b0; #1;
    push(8'h0); check("async_rst_write_enb", {5'd0, write_enb});
    step(); step();
    resetn = 1'b1;
    for (int n = 1; n <= TO + 1; n++) begin
      step();
      push((n == TO) ? 8'h2 : 8'h0);
      check($sformatf("p1_post_rst_edge%0d", n), {5'd0, soft_reset_2, soft_reset_1, soft_reset_0});
    end
    push(8'h0); check("post_rst_write_enb", {5'd0, write_enb});
    push(8'h0); check("post_rst_fifo_full", {7'd0, fifo_full});
    write_enb_reg = 1'b0;
    empty_1 = 1'b1;

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/router_sync.md
# router_sync

Address-capture and per-port supervision block of the 1x3 router, sitting between the router FSM and the three output FIFOs. It latches the destination address when the FSM decodes a header, steers the FSM's write enable to the selected FIFO, and returns that FIFO's full flag. It drives a valid-out per port and issues a one-cycle soft reset to any FIFO whose data sits unread for TIMEOUT cycles.

## Interface
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset of a port
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- detect_add  in  1  from FSM; capture data_in as destination address this edge
- data_in  in  2  header address field (00/01/10 valid, 11 invalid)
- write_enb_reg  in  1  from FSM; write request for the current packet byte
- read_enb_0/1/2  in  1 each  output-side read strobes
- empty_0/1/2  in  1 each  FIFO empty flags
- full_0/1/2  in  1 each  FIFO full flags
- write_enb  out  3  one-hot FIFO write enable, bit i = FIFO i
- fifo_full  out  1  full flag of the addressed FIFO, to FSM
- vld_out_0/1/2  out  1 each  FIFO i holds data
- soft_reset_0/1/2  out  1 each  registered one-cycle FIFO soft reset, to FSM and FIFO i

## Operation
- Address register addr (2 bits), reset value 2'b11 (no port selected).
- On a clock edge with detect_add=1: addr <= data_in, including 2'b11.
- write_enb (combinational): write_enb_reg=1 and addr=i (i in 0..2) -> bit i set, others 0; write_enb_reg=0 or addr=11 -> 3'b000.
- fifo_full (combinational) = full_addr; addr=11 -> 0.
- vld_out_i (combinational) = ~empty_i, independent of addr.
- Per-port timer cnt_i (CNT_W bits, reset 0), evaluated each edge:
  - vld_out_i=0 or read_enb_i=1 -> cnt_i <= 0, soft_reset_i <= 0.
  - else if cnt_i == TIMEOUT-1 -> cnt_i <= 0, soft_reset_i <= 1.
  - else -> cnt_i <= cnt_i+1, soft_reset_i <= 0.
- The three timers are fully independent; any number may fire on the same edge.
- resetn low at any time: addr=11, all cnt_i=0, all soft_reset_i=0 immediately (asynchronous), overriding an in-progress count.

## Timing
- write_enb and fifo_full follow addr and inputs in the same cycle; addr updates one edge after detect_add is sampled high. The capture cycle itself uses the old addr.
- detect_add and write_enb_reg high together: the write steers by the old addr, and the new addr takes effect the next cycle.
- soft_reset_i rises on the TIMEOUT-th consecutive edge sampling vld_out_i=1 and read_enb_i=0. It stays high exactly one cycle.
- A single read_enb_i=1 cycle anywhere in the window restarts the count from 0.
- If vld_out_i stays 1 after soft_reset_i (FIFO not yet cleared), counting restarts and fires again TIMEOUT edges later. It never re-fires back-to-back.
- Reset values: write_enb=000, fifo_full=0, soft_reset_*=0. vld_out_* reflect the empty inputs.

## Structure
- Shared package router_pkg: NUM_PORTS=3, ADDR_NONE=2'b11, default TIMEOUT=30, CNT_W=5. Reuse them in router_fsm and the FIFOs.
- One sub-module router_sync_timer (clock, resetn, vld, rd -> soft_reset), parameterised by TIMEOUT/CNT_W and instantiated three times.
- Address register, write_enb decode and fifo_full mux stay in the top level.

## Test plan
- Reset, then detect_add=1 with data_in=01, then write_enb_reg=1 -> write_enb=010 the cycle after capture; full_1=1 -> fifo_full=1; full_0=1 alone -> fifo_full=0.
- detect_add=1 with data_in=11, write_enb_reg=1 -> write_enb=000, fifo_full=0 regardless of full_*.
- empty_2=0, read_enb_2=0 held -> soft_reset_2 high exactly on the 30th edge for one cycle; held longer -> fires again at edge 60.
- empty_0=0 for 29 edges, read_enb_0=1 for one cycle at edge 20 -> no soft_reset_0; count restarts and fires 30 edges after the read.
- All three ports valid and unread from the same edge -> soft_reset_0/1/2 all pulse on the same edge.
- Assert resetn low at count 25 on port 1 -> cnt cleared. After release, a full 30 edges elapse before soft_reset_1; addr returns to 11 (write_enb=000).
